// File: rtl/riscv_mdu_iter.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Latency: 33 cycles for normal ops, 1 cycle for fast-path results; the result is held until resp_ready.
module riscv_mdu_iter #(
    parameter int ENABLE_MUL = 1,
    parameter int ENABLE_DIV = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] acc_q, acc_d, lo_q, lo_d, m_q, m_d, res_q, res_d;
    logic        neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;

    logic        a_neg, b_neg, is_div, class_en, div_zero, div_ovf, fast, div_ge;
    logic [31:0] a_abs, b_abs, fast_res, div_diff, quo_s, rem_s, final_res;
    logic [32:0] mul_sum, div_sh;
    logic [63:0] prod_s;

    // Operand conditioning at acceptance
    assign is_div   = req_op[2];
    assign a_neg    = req_a[31] && (req_op == OP_MULH || req_op == OP_MULHSU ||
                                    req_op == OP_DIV  || req_op == OP_REM);
    assign b_neg    = req_b[31] && (req_op == OP_MULH || req_op == OP_DIV || req_op == OP_REM);
    assign a_abs    = a_neg ? (32'd0 - req_a) : req_a;
    assign b_abs    = b_neg ? (32'd0 - req_b) : req_b;
    assign class_en = is_div ? (ENABLE_DIV != 0) : (ENABLE_MUL != 0);
    assign div_zero = is_div && (req_b == 32'd0);
    assign div_ovf  = is_div && !req_op[0] && (req_a == 32'h8000_0000) && (req_b == 32'hFFFF_FFFF);
    assign fast     = !class_en || div_zero || div_ovf;

    always_comb begin
        fast_res = 32'd0;
        if (!class_en)     fast_res = 32'd0;
        else if (div_zero) fast_res = req_op[1] ? req_a : 32'hFFFF_FFFF;
        else if (div_ovf)  fast_res = req_op[1] ? 32'd0 : 32'h8000_0000;
    end

    // One iteration: multiply shifts {carry,acc,lo} right; divide shifts {acc,lo} left
    assign mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, m_q} : 33'd0);
    assign div_sh   = {acc_q, lo_q[31]};
    assign div_ge   = div_sh >= {1'b0, m_q};
    assign div_diff = div_sh[31:0] - m_q;

    assign prod_s = neg_res_q ? (64'd0 - {acc_q, lo_q}) : {acc_q, lo_q};
    assign quo_s  = neg_res_q ? (32'd0 - lo_q) : lo_q;
    assign rem_s  = neg_rem_q ? (32'd0 - acc_q) : acc_q;

    always_comb begin
        final_res = rem_s;
        case (op_q)
            OP_MUL:                        final_res = prod_s[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_s[63:32];
            OP_DIV, OP_DIVU:               final_res = quo_s;
            default:                       final_res = rem_s;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        m_d       = m_q;
        res_d     = res_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d      = req_op;
                    cnt_d     = 6'd0;
                    acc_d     = 32'd0;
                    lo_d      = is_div ? a_abs : b_abs;
                    m_d       = is_div ? b_abs : a_abs;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    if (fast) begin
                        res_d   = fast_res;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (cnt_q == 6'd32) begin
                    res_d   = final_res;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    if (op_q[2]) begin
                        acc_d = div_ge ? div_diff : div_sh[31:0];
                        lo_d  = {lo_q[30:0], div_ge};
                    end else begin
                        acc_d = mul_sum[32:1];
                        lo_d  = {mul_sum[0], lo_q[31:1]};
                    end
                end
            end
            DONE: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            op_q      <= 3'd0;
            acc_q     <= 32'd0;
            lo_q      <= 32'd0;
            m_q       <= 32'd0;
            res_q     <= 32'd0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            lo_q      <= lo_d;
            m_q       <= m_d;
            res_q     <= res_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign resp_result = res_q;
endmodule

// File: tb/tb_riscv_mdu_iter.sv
// Randomized bench for riscv_mdu_iter against an arithmetic RV32M reference model.
module tb_riscv_mdu_iter;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        req_valid, req_ready, resp_valid, resp_ready, busy;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b, resp_result;

    logic        nd_req_valid, nd_req_ready, nd_resp_valid, nd_busy;
    logic [2:0]  nd_req_op;
    logic [31:0] nd_req_a, nd_req_b, nd_resp_result;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    riscv_mdu_iter dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .busy(busy)
    );

    riscv_mdu_iter #(.ENABLE_MUL(1), .ENABLE_DIV(0)) dut_nd (
        .i_clk(i_clk), .i_rst(i_rst),
        .req_valid(nd_req_valid), .req_ready(nd_req_ready), .req_op(nd_req_op),
        .req_a(nd_req_a), .req_b(nd_req_b),
        .resp_valid(nd_resp_valid), .resp_ready(1'b1),
        .resp_result(nd_resp_result), .busy(nd_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        logic [63:0] p;
        int ia = a;
        int ib = b;
        bit ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 0;
        return 33;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called at #1 after the acceptance edge; counts edges until resp_valid.
    task automatic wait_resp(input string tag, input logic [31:0] exp, input int exp_lat);
        int lat = 0;
        req_valid = 1'b0;
        req_op = 3'($urandom);
        req_a = $urandom;
        req_b = $urandom;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (!resp_valid && lat < 100) begin
            @(posedge i_clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check(tag, resp_result, exp);
        if (resp_ready) begin
            @(posedge i_clk); #1;
            check({tag, "_vld_low"}, 32'(resp_valid), 32'd0);
            check({tag, "_rdy_idle"}, 32'(req_ready), 32'd1);
            check({tag, "_held"}, resp_result, exp);
        end
    endtask

    task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge i_clk); #1;
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        @(posedge i_clk); #1;
        wait_resp(tag, ref_res(op, a, b), ref_lat(op, a, b));
    endtask

    initial begin
        int vld_seen;
        logic [2:0]  op;
        logic [31:0] a, b;
        i_rst = 1'b1;
        resp_ready = 1'b1;
        nd_req_valid = 1'b0;
        nd_req_op = 3'd0;
        nd_req_a = 32'd0;
        nd_req_b = 32'd0;
        req_valid = 1'b1;
        req_op = 3'd0;
        req_a = 32'd7;
        req_b = 32'hFFFF_FFFD;
        repeat (2) @(negedge i_clk);
        check("rst_vld", 32'(resp_valid), 32'd0);
        check("rst_res", resp_result, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdy", 32'(req_ready), 32'd1);
        i_rst = 1'b0;
        // First edge after release accepts the pending MUL
        @(posedge i_clk); #1;
        wait_resp("mul_first", 32'hFFFF_FFEB, 33);

        issue("mulhu",       3'd3, 32'd7, 32'hFFFF_FFFD);
        issue("mulh_min",    3'd1, 32'h8000_0000, 32'h8000_0000);
        issue("mulhsu_m1",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue("div_neg",     3'd4, 32'hFFFF_FFF9, 32'd2);
        issue("rem_neg",     3'd6, 32'hFFFF_FFF9, 32'd2);
        issue("divu",        3'd5, 32'd100, 32'd7);
        issue("remu",        3'd7, 32'd100, 32'd7);
        issue("divu_z",      3'd5, 32'd55, 32'd0);
        issue("remu_z",      3'd7, 32'h1234, 32'd0);
        issue("div_ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        issue("rem_ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // Response held with resp_ready low; new requests must be ignored
        resp_ready = 1'b0;
        issue("hold", 3'd5, 32'd100, 32'd7);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_op = 3'd0;
            req_a = $urandom;
            req_b = $urandom;
            @(posedge i_clk); #1;
            check("hold_vld", 32'(resp_valid), 32'd1);
            check("hold_res", resp_result, 32'd14);
            check("hold_rdy", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge i_clk); #1;
        check("hold_rel_vld", 32'(resp_valid), 32'd0);
        check("hold_rel_rdy", 32'(req_ready), 32'd1);
        check("hold_rel_res", resp_result, 32'd14);

        // Reset in the middle of a multiply
        @(posedge i_clk); #1;
        req_valid = 1'b1;
        req_op = 3'd0;
        req_a = 32'd9;
        req_b = 32'd9;
        @(posedge i_clk); #1;
        req_valid = 1'b0;
        repeat (16) @(posedge i_clk);
        #1 i_rst = 1'b1;
        #1;
        check("midrst_vld", 32'(resp_valid), 32'd0);
        check("midrst_res", resp_result, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        vld_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge i_clk); #1;
            if (resp_valid) vld_seen++;
        end
        check("midrst_no_resp", 32'(vld_seen), 32'd0);
        check("midrst_rdy", 32'(req_ready), 32'd1);
        issue("mul_after_rst", 3'd0, 32'd3, 32'd4);

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom);
            a = rand_operand();
            b = rand_operand();
            issue($sformatf("rnd%0d_op%0d", i, op), op, a, b);
        end

        // Divide class disabled: fast path with zero result; multiply still iterates
        for (int k = 0; k < 2; k++) begin
            int lat = 0;
            @(posedge i_clk); #1;
            nd_req_valid = 1'b1;
            nd_req_op = (k == 0) ? 3'd4 : 3'd0;
            nd_req_a = (k == 0) ? 32'd10 : 32'd3;
            nd_req_b = (k == 0) ? 32'd2 : 32'd4;
            @(posedge i_clk); #1;
            nd_req_valid = 1'b0;
            while (!nd_resp_valid && lat < 100) begin
                @(posedge i_clk); #1;
                lat++;
            end
            check((k == 0) ? "nodiv_lat" : "nodiv_mul_lat", 32'(lat), (k == 0) ? 32'd0 : 32'd33);
            check((k == 0) ? "nodiv_res" : "nodiv_mul_res", nd_resp_result, (k == 0) ? 32'd0 : 32'd12);
            @(posedge i_clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/riscv_mdu_iter.md
RISCV_MDU_ITER -- requirements
Module: riscv_mdu_iter

Interface
REQ-001 Parameter ENABLE_MUL, default 1, SHALL enable MUL/MULH/MULHSU/MULHU when 1.
REQ-002 Parameter ENABLE_DIV, default 1, SHALL enable DIV/DIVU/REM/REMU when 1.
REQ-003 i_clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 i_rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 req_valid  input  1  SHALL indicate the initiator presents an operation.
REQ-006 req_ready  output  1  SHALL indicate the unit accepts an operation this cycle.
REQ-007 req_op  input  3  SHALL select the op in funct3 encoding (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-008 req_a, req_b  input  32 each  SHALL carry rs1 and rs2.
REQ-009 resp_valid  output  1  SHALL indicate resp_result holds a completed result.
REQ-010 resp_ready  input  1  SHALL indicate the initiator consumes the result.
REQ-011 resp_result  output  32  SHALL carry the RV32M result.
REQ-012 busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, CALC, DONE; req_ready SHALL equal (state == IDLE).
REQ-014 Acceptance SHALL occur on a rising edge with req_valid && req_ready; op, operands and sign flags are latched then, and req_* is ignored at all other times.
REQ-015 On acceptance of a normal op, FSM SHALL enter CALC with iteration counter 0, take absolute values of signed operands (MULH: both; MULHSU: a only; DIV/REM: both), and run exactly 32 iterations, one per cycle.
REQ-016 Multiply SHALL be radix-2 shift-add producing a 64-bit unsigned product; divide SHALL be restoring, producing 32-bit quotient and remainder.
REQ-017 After iteration 32, FSM SHALL enter DONE with resp_result registered: sign-corrected (product negated if signs differ; quotient negated if signs differ; remainder takes sign of dividend), then MUL low 32 bits, MULH/MULHSU/MULHU high 32 bits.
REQ-018 Normal-op latency SHALL be 33 cycles: acceptance edge t0, resp_valid high from the cycle after edge t33.
REQ-019 Fast path, acceptance edge -> DONE directly (resp_valid in the next cycle): divisor 0 (DIV/DIVU -> 0xFFFFFFFF, REM/REMU -> req_a); DIV/REM with a = 0x80000000 and b = 0xFFFFFFFF (DIV -> 0x80000000, REM -> 0); op whose class is disabled by parameter (result 0).
REQ-020 In DONE, resp_valid SHALL be high and resp_result stable until resp_ready is high on an edge, which returns FSM to IDLE.
REQ-021 A request SHALL NOT be accepted in the same cycle a response is consumed; req_ready first rises the cycle after return to IDLE.
REQ-022 resp_result SHALL hold its last value in IDLE and CALC; resp_valid SHALL be low outside DONE.
REQ-023 Operand changes on req_* during CALC/DONE SHALL NOT affect the in-flight result.
REQ-024 Counter SHALL be 6 bits, never wrap, and be cleared on every acceptance.

Reset
REQ-025 i_rst high SHALL immediately force state IDLE, counter 0, resp_valid 0, resp_result 0x00000000, busy 0, req_ready 1 after release.
REQ-026 Reset asserted mid-CALC or in DONE SHALL discard the operation; no response SHALL be produced for it.
REQ-027 First acceptance SHALL be possible on the first rising edge after i_rst deasserts.

Verification
REQ-028 MUL a=7, b=0xFFFFFFFD, resp_ready=1 -> resp_valid after edge t33, resp_result 0xFFFFFFEB; MULHU same operands -> 0x00000006.
REQ-029 MULH a=b=0x80000000 -> 0x40000000; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-030 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-031 DIVU b=0 -> 0xFFFFFFFF, REMU a=0x1234, b=0 -> 0x1234, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, each with resp_valid one cycle after acceptance.
REQ-032 resp_ready held low 5 cycles in DONE -> resp_valid and resp_result stable, req_ready low, new req_valid ignored; ENABLE_DIV=0, DIV 10/2 -> 0 via fast path.
REQ-033 i_rst pulsed at iteration 16 of a MUL -> outputs return to reset values immediately, no resp_valid for that op, next MUL 3*4 -> 12 after 33 cycles.
